// File: rtl/fifo_read_skid_buffer.sv
// Two-entry registered output stage on the FIFO read port. The pop enable is
// decoded from registered state only, so the consumer's ready never reaches the FIFO.
module fifo_read_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             fifo_read_empty,
    input  logic [WIDTH-1:0] fifo_read_data,
    output logic             fifo_read_enable,
    output logic             read_valid,
    input  logic             read_ready,
    output logic [WIDTH-1:0] read_data,
    output logic [1:0]       buffer_level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             pop;
    logic             transfer;

    // State encoding doubles as the entry count.
    assign buffer_level     = state;
    assign read_valid       = (state != EMPTY);
    assign read_data        = main_q;
    assign transfer         = read_valid & read_ready;
    assign pop              = ~fifo_read_empty & (state != TWO) & ~flush;
    assign fifo_read_enable = pop;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (pop) begin
                        state  <= ONE;
                        main_q <= fifo_read_data;
                    end
                end
                ONE: begin
                    case ({pop, transfer})
                        2'b11: main_q <= fifo_read_data;
                        2'b10: begin
                            state  <= TWO;
                            skid_q <= fifo_read_data;
                        end
                        2'b01: state <= EMPTY;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (transfer) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_skid_buffer.sv
// Directed and randomized checks of fifo_read_skid_buffer against a FIFO model
// and an in-order scoreboard of entries held inside the buffer.
module tb_fifo_read_skid_buffer;

    logic       clock;
    logic       resetn;
    logic       flush;
    logic       fifo_read_empty;
    logic [7:0] fifo_read_data;
    logic       fifo_read_enable;
    logic       read_valid;
    logic       read_ready;
    logic [7:0] read_data;
    logic [1:0] buffer_level;

    logic       hold_empty;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         vectors;
    int         miscompares;

    fifo_read_skid_buffer #(.WIDTH(8)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .flush            (flush),
        .fifo_read_empty  (fifo_read_empty),
        .fifo_read_data   (fifo_read_data),
        .fifo_read_enable (fifo_read_enable),
        .read_valid       (read_valid),
        .read_ready       (read_ready),
        .read_data        (read_data),
        .buffer_level     (buffer_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_read_empty = hold_empty | (fifo_q.size() == 0);
        fifo_read_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        refresh();
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    // Monitor: the scoreboard holds exactly the entries popped into the DUT and not yet consumed.
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
            check("rst_valid", {31'd0, read_valid}, 32'd0);
            check("rst_pop", {31'd0, fifo_read_enable}, {31'd0, ~fifo_read_empty & ~flush});
        end else begin
            check("level", {30'd0, buffer_level}, exp_q.size());
            check("valid", {31'd0, read_valid}, {31'd0, exp_q.size() != 0});
            check("pop", {31'd0, fifo_read_enable},
                  {31'd0, !fifo_read_empty && exp_q.size() < 2 && !flush});
            if (read_valid && exp_q.size() != 0) begin
                check("head", {24'd0, read_data}, {24'd0, exp_q[0]});
                if (read_ready) void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (fifo_read_enable && !fifo_read_empty && fifo_q.size() != 0)
                exp_q.push_back(fifo_q[0]);
        end
        if (fifo_read_enable && !fifo_read_empty && fifo_q.size() != 0)
            void'(fifo_q.pop_front());
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        hold_empty  = 1'b1;
        read_ready  = 1'b0;
        flush       = 1'b0;
        refresh();
        #1;
        check("rst_data", {24'd0, read_data}, 32'd0);
        check("rst_level", {30'd0, buffer_level}, 32'd0);
        cyc();
        cyc();
        resetn     = 1'b1;
        hold_empty = 1'b0;
        refresh();

        // Latency: non-empty in cycle N, pop in N, valid in N+1
        cyc();
        fifo_q.push_back(8'h11);
        refresh();
        at_neg();
        check("lat_pop", {31'd0, fifo_read_enable}, 32'd1);
        check("lat_valid_n", {31'd0, read_valid}, 32'd0);
        cyc();
        at_neg();
        check("lat_valid_n1", {31'd0, read_valid}, 32'd1);
        check("lat_data_n1", {24'd0, read_data}, 32'h11);
        cyc();
        read_ready = 1'b1;
        cyc();
        read_ready = 1'b0;

        // Streaming at one transfer per cycle
        cyc();
        read_ready = 1'b1;
        for (int k = 1; k <= 8; k++) fifo_q.push_back(8'(k));
        refresh();
        at_neg();
        check("stream_pop0", {31'd0, fifo_read_enable}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            at_neg();
            check("stream_data", {24'd0, read_data}, k);
            check("stream_level", {30'd0, buffer_level}, 32'd1);
            if (k < 8) check("stream_pop", {31'd0, fifo_read_enable}, 32'd1);
        end
        cyc();
        read_ready = 1'b0;
        at_neg();
        check("stream_done", {30'd0, buffer_level}, 32'd0);

        // Stall to level 2, then drain
        cyc();
        fifo_q.push_back(8'hA0);
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        refresh();
        cyc();
        cyc();
        at_neg();
        check("stall_level", {30'd0, buffer_level}, 32'd2);
        check("stall_nopop", {31'd0, fifo_read_enable}, 32'd0);
        check("stall_data", {24'd0, read_data}, 32'hA0);
        cyc();
        read_ready = 1'b1;
        at_neg();
        check("drain1_data", {24'd0, read_data}, 32'hA0);
        check("drain1_nopop", {31'd0, fifo_read_enable}, 32'd0);
        cyc();
        at_neg();
        check("drain2_data", {24'd0, read_data}, 32'hA1);
        check("drain2_level", {30'd0, buffer_level}, 32'd1);
        check("drain2_pop", {31'd0, fifo_read_enable}, 32'd1);
        cyc();
        at_neg();
        check("drain3_data", {24'd0, read_data}, 32'hA2);
        cyc();
        read_ready = 1'b0;
        at_neg();
        check("drain_done", {30'd0, buffer_level}, 32'd0);

        // Flush at level 2 with ready high, then flush with FIFO non-empty
        cyc();
        fifo_q.push_back(8'hA0);
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        refresh();
        cyc();
        cyc();
        flush      = 1'b1;
        read_ready = 1'b1;
        at_neg();
        check("flush_level", {30'd0, buffer_level}, 32'd2);
        check("flush_nopop", {31'd0, fifo_read_enable}, 32'd0);
        cyc();
        flush      = 1'b0;
        read_ready = 1'b0;
        at_neg();
        check("flush_valid", {31'd0, read_valid}, 32'd0);
        check("flush_level0", {30'd0, buffer_level}, 32'd0);
        check("flush_resume", {31'd0, fifo_read_enable}, 32'd1);
        cyc();
        fifo_q.push_back(8'hA3);
        refresh();
        flush      = 1'b1;
        read_ready = 1'b1;
        at_neg();
        check("flush1_data", {24'd0, read_data}, 32'hA2);
        check("flush1_nopop", {31'd0, fifo_read_enable}, 32'd0);
        cyc();
        flush = 1'b0;
        at_neg();
        check("flush1_level", {30'd0, buffer_level}, 32'd0);
        check("flush1_pop", {31'd0, fifo_read_enable}, 32'd1);
        cyc();
        at_neg();
        check("flush1_next", {24'd0, read_data}, 32'hA3);
        cyc();
        read_ready = 1'b0;

        // Asynchronous reset mid-clock at level 2
        cyc();
        fifo_q.push_back(8'hB0);
        fifo_q.push_back(8'hB1);
        fifo_q.push_back(8'hB2);
        refresh();
        cyc();
        cyc();
        #2;
        resetn     = 1'b0;
        hold_empty = 1'b1;
        refresh();
        #1;
        check("arst_valid", {31'd0, read_valid}, 32'd0);
        check("arst_data", {24'd0, read_data}, 32'd0);
        check("arst_level", {30'd0, buffer_level}, 32'd0);
        cyc();
        cyc();
        resetn     = 1'b1;
        hold_empty = 1'b0;
        refresh();
        at_neg();
        check("arst_pop", {31'd0, fifo_read_enable}, 32'd1);
        cyc();
        at_neg();
        check("arst_next_valid", {31'd0, read_valid}, 32'd1);
        check("arst_next_data", {24'd0, read_data}, 32'hB2);
        cyc();
        read_ready = 1'b1;
        cyc();
        read_ready = 1'b0;

        // Random empty/ready/flush patterns
        for (int i = 0; i < 10000; i++) begin
            cyc();
            hold_empty = ($urandom_range(3) == 0);
            read_ready = 1'($urandom_range(1));
            flush      = ($urandom_range(63) == 0);
            if (fifo_q.size() < 4 && $urandom_range(1) == 1) fifo_q.push_back(8'($urandom));
            refresh();
        end
        cyc();
        hold_empty = 1'b0;
        flush      = 1'b0;
        read_ready = 1'b1;
        refresh();
        repeat (12) cyc();
        check("drain_all", exp_q.size() + fifo_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_read_skid_buffer.md
# fifo_read_skid_buffer

Two-entry registered output stage placed directly downstream of the asynchronous FIFO controller read port, in the read clock domain. It pops the FIFO through its empty/enable interface and presents the data to the consumer on a valid/ready handshake with registered valid and data outputs. The FIFO pop enable never depends combinationally on the consumer's ready. Steady streaming runs at one transfer per cycle.

## Interface
- WIDTH, 8, data width in bits; must match the FIFO WIDTH.
- clock  input  1  read-domain clock; all state changes on its rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous discard of all buffered entries.
- fifo_read_empty  input  1  FIFO empty flag.
- fifo_read_data  input  WIDTH  FIFO head data; valid in the same cycle whenever fifo_read_empty is low.
- fifo_read_enable  output  1  FIFO pop, one entry per cycle when high.
- read_valid  output  1  registered; read_data holds an entry.
- read_ready  input  1  consumer accepts the entry.
- read_data  output  WIDTH  registered head entry.
- buffer_level  output  2  number of buffered entries, 0 to 2.

## Operation
- Storage:
  - main register: the head entry, drives read_data.
  - skid register: the second entry.
  - state: EMPTY, ONE or TWO; buffer_level is 0, 1 or 2 to match.
- Outputs:
  - read_valid = (state != EMPTY).
  - transfer = read_valid & read_ready.
  - pop = fifo_read_enable = ~fifo_read_empty & (state != TWO) & ~flush.
  - pop depends only on registered state, the empty flag and flush.
- Transitions, with no flush:
  - EMPTY: pop -> ONE, main <= fifo_read_data. No pop -> stay EMPTY.
  - ONE, pop & transfer -> ONE, main <= fifo_read_data.
  - ONE, pop & ~transfer -> TWO, skid <= fifo_read_data.
  - ONE, ~pop & transfer -> EMPTY.
  - ONE, ~pop & ~transfer -> stay ONE.
  - TWO: pop is impossible. Transfer -> ONE, main <= skid. No transfer -> stay TWO.
- Flush:
  - Next state is EMPTY and pop is forced low.
  - A transfer in the flush cycle counts as completed.
  - Every other buffered entry is discarded. The FIFO contents are untouched.
- Ordering: entries leave in exactly the order they were popped. Nothing is dropped or duplicated except by flush.
- Stability: while read_valid & ~read_ready, read_data and read_valid hold their values.
- read_ready may be high while read_valid is low; it has no effect then.
- Data registers load only on the transitions listed above. Their contents are don't-care in EMPTY, but they reset to 0.

## Timing
- Reset (asynchronous, active-low):
  - state EMPTY, read_valid 0, read_data 0, buffer_level 0, main and skid 0.
  - While in reset, fifo_read_enable = ~fifo_read_empty & ~flush. No state updates occur until resetn deasserts.
  - Reset asserted mid-operation discards both entries immediately, with no partial transfer.
- Latency: FIFO becomes non-empty in cycle N -> pop in N -> read_valid and read_data valid in N+1.
- Throughput:
  - Back-to-back transfers at 1 per cycle while the FIFO is non-empty and read_ready is held high; state stays ONE.
  - After a stall reaches TWO, the first ready cycle drains to ONE with no pop. Popping resumes the following cycle, so the buffer never starves the consumer.
- Simultaneous events:
  - Pop and transfer in ONE: the new entry replaces the consumed one in the same edge.
  - Flush together with fifo_read_empty deasserted: no pop.
- The empty flag may deassert one or more cycles late (synchronizer latency). The block tolerates any empty-flag pattern. It never pops while fifo_read_empty is high.

## Test plan
- Reset, then FIFO non-empty with data 0x11 in cycle N, ready low:
  - fifo_read_enable high in N.
  - read_valid=1 and read_data=0x11 from N+1.
- Stream 0x01..0x08 with read_ready held high:
  - 8 transfers in consecutive cycles, in order.
  - buffer_level stays 1; fifo_read_enable never drops while the FIFO is non-empty.
- Stall: load 0xA0 and 0xA1 with ready low:
  - level reaches 2, fifo_read_enable drops, read_data stays 0xA0.
  - Raise ready: 0xA0 transfers, then 0xA1 the next cycle, with the pop resuming after the first drain.
- Level 2, assert flush with ready high for one cycle:
  - 0xA0 counts as transferred and 0xA1 is discarded.
  - read_valid=0 and buffer_level=0 next cycle; no pop in the flush cycle.
- Assert resetn low asynchronously, mid-clock, while at level 2:
  - read_valid, read_data and buffer_level go to 0 immediately.
  - After release, the next FIFO entry appears first.
- Random empty and ready patterns over 10k cycles:
  - The scoreboard matches the pop order to the transfer order.
  - fifo_read_enable is never high while fifo_read_empty is high.
  - read_data is stable whenever read_valid=1 and read_ready=0.
